// File: rtl/cond_unit_banked_if.sv
// Decoder-to-condition-unit bundle: issuing instruction fields, datapath flags,
// multi-cycle unit handshake and the gated write enables.
interface cond_unit_banked_if #(
    parameter int BW = 1
);
    logic [3:0]    Cond;
    logic [BW-1:0] BankSel;
    logic [3:0]    FlagW;
    logic          PCS;
    logic          RegW;
    logic          MemW;
    logic          NoWrite;
    logic          LogicOp;
    logic [3:0]    ALUFlags;
    logic          ShifterCarry;
    logic          FlagLoad;
    logic [3:0]    FlagIn;
    logic          MS;
    logic          MDone;
    logic [3:0]    MFlags;
    logic          PCSrc;
    logic          RegWrite;
    logic          MemWrite;
    logic          MStart;
    logic          MRegWrite;
    logic          Stall;
    logic          Busy;
    logic [3:0]    Flags;
    logic          CFlag;

    modport master (
        output Cond, BankSel, FlagW, PCS, RegW, MemW, NoWrite, LogicOp,
               ALUFlags, ShifterCarry, FlagLoad, FlagIn, MS, MDone, MFlags,
        input  PCSrc, RegWrite, MemWrite, MStart, MRegWrite, Stall, Busy,
               Flags, CFlag
    );

    modport slave (
        input  Cond, BankSel, FlagW, PCS, RegW, MemW, NoWrite, LogicOp,
               ALUFlags, ShifterCarry, FlagLoad, FlagIn, MS, MDone, MFlags,
        output PCSrc, RegWrite, MemWrite, MStart, MRegWrite, Stall, Busy,
               Flags, CFlag
    );
endinterface

// File: rtl/cond_unit_banked.sv
// Banked ARM condition unit: checks Cond against one of NBANK NZCV sets, gates the
// write enables, and tracks one outstanding multi-cycle op with flag write-back.
module cond_unit_banked #(
    parameter int NBANK = 2,
    parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input logic               CLK,
    input logic               Reset,
    cond_unit_banked_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [3:0]    bank [NBANK];
    logic [3:0]    mflagw;
    logic [BW-1:0] mbank;

    logic          mdone_acc;
    logic          stall;
    logic          hit;
    logic          cond_ex;
    logic          issue;
    logic          mstart;
    logic [3:0]    sel_flags;
    logic [3:0]    byp_mask;
    logic [3:0]    eff;
    logic [3:0]    issue_wr;
    logic [3:0]    issue_data;
    logic          n, z, c, v;

    assign mdone_acc = (state == BUSY) && bus.MDone;
    assign stall     = (state == BUSY) && !bus.MDone;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel_flags = 4'b0000;
        hit       = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            if (BW'(b) == bus.BankSel) begin
                sel_flags = bank[b];
                hit       = 1'b1;
            end
        end
    end

    // The instruction released on the completion cycle must see the finished op's flags.
    assign byp_mask     = (mdone_acc && hit && (mbank == bus.BankSel)) ? mflagw : 4'b0000;
    assign eff          = (sel_flags & ~byp_mask) | (bus.MFlags & byp_mask);
    assign {n, z, c, v} = eff;

    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = !c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = c && !z;
            4'b1001: cond_ex = !c || z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = !z && (n == v);
            4'b1101: cond_ex = z || (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Stall is only low in BUSY on the MDone cycle, so this also covers back-to-back starts.
    assign issue  = cond_ex && !stall;
    assign mstart = bus.MS && issue;

    assign bus.PCSrc     = bus.PCS && issue;
    assign bus.RegWrite  = bus.RegW && issue && !bus.NoWrite;
    assign bus.MemWrite  = bus.MemW && issue;
    assign bus.MStart    = mstart;
    assign bus.MRegWrite = mdone_acc;
    assign bus.Stall     = stall;
    assign bus.Busy      = (state == BUSY);
    assign bus.Flags     = sel_flags;
    assign bus.CFlag     = sel_flags[1];

    // A starting op defers its FlagW to completion; FlagLoad always writes all four bits.
    always_comb begin
        issue_wr   = 4'b0000;
        issue_data = {bus.ALUFlags[3], bus.ALUFlags[2],
                      bus.LogicOp ? bus.ShifterCarry : bus.ALUFlags[1],
                      bus.ALUFlags[0]};
        if (issue) begin
            if (bus.FlagLoad) begin
                issue_wr   = 4'b1111;
                issue_data = bus.FlagIn;
            end else if (!mstart) begin
                issue_wr = bus.FlagW;
            end
        end
    end

    // NOTE: the flag banks are a handful of flops, so they take the async reset like any state.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int b = 0; b < NBANK; b++) begin
                bank[b] <= 4'b0000;
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                for (int i = 0; i < 4; i++) begin
                    // Issue is later in program order than the completing op, so it wins.
                    if (issue_wr[i] && (BW'(b) == bus.BankSel)) begin
                        bank[b][i] <= issue_data[i];
                    end else if (mdone_acc && mflagw[i] && (BW'(b) == mbank)) begin
                        bank[b][i] <= bus.MFlags[i];
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            mflagw <= 4'b0000;
            mbank  <= '0;
        end else if (mstart) begin
            state  <= BUSY;
            mflagw <= bus.FlagW;
            mbank  <= bus.BankSel;
        end else if (mdone_acc) begin
            state  <= IDLE;
        end
    end
endmodule

// File: tb/tb_cond_unit_banked.sv
// Self-checking bench for cond_unit_banked: directed scenarios with literal
// expectations, then randomized traffic against a behavioural flag-bank model.
module tb_cond_unit_banked;
    localparam int NBANK = 3;
    localparam int BW    = 2;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cond_unit_banked_if #(.BW(BW)) bus ();

    cond_unit_banked #(.NBANK(NBANK), .BW(BW)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cond)
            4'd0:    return fz;
            4'd1:    return !fz;
            4'd2:    return fc;
            4'd3:    return !fc;
            4'd4:    return fn;
            4'd5:    return !fn;
            4'd6:    return fv;
            4'd7:    return !fv;
            4'd8:    return fc && !fz;
            4'd9:    return !fc || fz;
            4'd10:   return fn == fv;
            4'd11:   return fn != fv;
            4'd12:   return !fz && (fn == fv);
            4'd13:   return fz || (fn != fv);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural model: flag banks, one pending op (busy, its flag mask and bank).
    logic [3:0] mb [NBANK];
    logic       m_busy;
    logic [3:0] m_fw;
    int         m_bank;

    initial begin : compare
        int         bs;
        logic [3:0] eff, e_flags, alu_val;
        logic       e_cex, e_stall, e_issue, e_mstart, e_mreg;
        forever begin
            @(negedge CLK);
            if (Reset) begin
                for (int b = 0; b < NBANK; b++) mb[b] = 4'b0000;
                m_busy = 1'b0;
                m_fw   = 4'b0000;
                m_bank = 0;
            end
            bs      = int'(bus.BankSel);
            e_flags = 4'b0000;
            if (bs < NBANK) e_flags = mb[bs];
            eff = e_flags;
            if (m_busy && bus.MDone && bs == m_bank && bs < NBANK)
                for (int i = 0; i < 4; i++) if (m_fw[i]) eff[i] = bus.MFlags[i];
            e_cex    = cond_true(bus.Cond, eff);
            e_stall  = m_busy && !bus.MDone;
            e_issue  = e_cex && !e_stall;
            e_mstart = bus.MS && e_issue;
            e_mreg   = m_busy && bus.MDone;

            check("PCSrc",     4'(bus.PCSrc),     4'(bus.PCS && e_issue));
            check("RegWrite",  4'(bus.RegWrite),  4'(bus.RegW && e_issue && !bus.NoWrite));
            check("MemWrite",  4'(bus.MemWrite),  4'(bus.MemW && e_issue));
            check("MStart",    4'(bus.MStart),    4'(e_mstart));
            check("MRegWrite", 4'(bus.MRegWrite), 4'(e_mreg));
            check("Stall",     4'(bus.Stall),     4'(e_stall));
            check("Busy",      4'(bus.Busy),      4'(m_busy));
            check("Flags",     bus.Flags,         e_flags);
            check("CFlag",     4'(bus.CFlag),     4'(e_flags[1]));

            if (!Reset) begin
                if (e_mreg && m_bank < NBANK)
                    for (int i = 0; i < 4; i++) if (m_fw[i]) mb[m_bank][i] = bus.MFlags[i];
                if (e_issue && bs < NBANK) begin
                    alu_val = bus.ALUFlags;
                    if (bus.LogicOp) alu_val[1] = bus.ShifterCarry;
                    if (bus.FlagLoad) mb[bs] = bus.FlagIn;
                    else if (!e_mstart)
                        for (int i = 0; i < 4; i++) if (bus.FlagW[i]) mb[bs][i] = alu_val[i];
                end
                if (e_mstart) begin
                    m_busy = 1'b1;
                    m_fw   = bus.FlagW;
                    m_bank = bs;
                end else if (e_mreg) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear();
        bus.Cond = 4'b1110; bus.BankSel = '0; bus.FlagW = 4'b0000;
        bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
        bus.LogicOp = 1'b0; bus.ALUFlags = 4'b0000; bus.ShifterCarry = 1'b0;
        bus.FlagLoad = 1'b0; bus.FlagIn = 4'b0000; bus.MS = 1'b0;
        bus.MDone = 1'b0; bus.MFlags = 4'b0000;
    endtask

    initial begin : stimulus
        clear();
        repeat (2) tick();
        Reset = 1'b0;

        // EQ after reset is false; SUBS sets Z; EQ branch then taken.
        bus.Cond = 4'b0000; bus.RegW = 1'b1; #1;
        check("eq_after_reset", 4'(bus.RegWrite), 4'd0);
        check("flags_after_reset", bus.Flags, 4'b0000);
        tick(); clear();
        bus.RegW = 1'b1; bus.FlagW = 4'b1111; bus.ALUFlags = 4'b0100;
        tick(); clear();
        bus.Cond = 4'b0000; bus.PCS = 1'b1; #1;
        check("subs_flags", bus.Flags, 4'b0100);
        check("beq_taken", 4'(bus.PCSrc), 4'd1);

        // Logical ops take the shifter carry; CMP updates flags without a register write.
        tick(); clear();
        bus.FlagW = 4'b0010; bus.LogicOp = 1'b1; bus.ShifterCarry = 1'b1;
        tick(); clear();
        bus.FlagW = 4'b0010; bus.ShifterCarry = 1'b1; #1;
        check("ands_c_shifter", bus.Flags, 4'b0110);
        check("cflag_out", 4'(bus.CFlag), 4'd1);
        tick(); clear();
        bus.RegW = 1'b1; bus.NoWrite = 1'b1; bus.FlagW = 4'b1111; bus.ALUFlags = 4'b1000; #1;
        check("ands_c_alu", bus.Flags, 4'b0100);
        check("cmp_no_regwrite", 4'(bus.RegWrite), 4'd0);
        tick(); clear(); #1;
        check("cmp_flags", bus.Flags, 4'b1000);

        // Bank 1 = 0001 (N!=V, V set), bank 0 = 0000.
        bus.BankSel = 2'd1; bus.FlagLoad = 1'b1; bus.FlagIn = 4'b0001;
        tick(); clear();
        bus.FlagLoad = 1'b1;
        tick(); clear();
        bus.BankSel = 2'd1; bus.PCS = 1'b1; bus.Cond = 4'b1010; #1;
        check("bank1_ge", 4'(bus.PCSrc), 4'd0);
        bus.Cond = 4'b0110; #1;
        check("bank1_vs", 4'(bus.PCSrc), 4'd1);
        check("bank1_flags", bus.Flags, 4'b0001);
        tick();
        bus.BankSel = 2'd0; #1;
        check("bank0_vs", 4'(bus.PCSrc), 4'd0);
        bus.Cond = 4'b1010; #1;
        check("bank0_ge", 4'(bus.PCSrc), 4'd1);

        // Unimplemented bank: write dropped, reads 0.
        tick(); clear();
        bus.BankSel = 2'd3; bus.FlagLoad = 1'b1; bus.FlagIn = 4'b1111;
        tick(); clear();
        bus.BankSel = 2'd3; bus.Cond = 4'b0001; bus.PCS = 1'b1; #1;
        check("oob_flags", bus.Flags, 4'b0000);
        check("oob_ne", 4'(bus.PCSrc), 4'd1);

        // MULS, three stall cycles, completion bypass to the waiting BEQ.
        tick(); clear();
        bus.MS = 1'b1; bus.RegW = 1'b1; bus.FlagW = 4'b1100; #1;
        check("muls_mstart", 4'(bus.MStart), 4'd1);
        check("muls_flags_deferred_pre", bus.Flags, 4'b0000);
        tick(); clear();
        bus.Cond = 4'b0000; bus.PCS = 1'b1; bus.RegW = 1'b1; bus.MemW = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("busy_stall", 4'(bus.Stall), 4'd1);
            check("busy_enables", {1'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 4'b0000);
            check("busy_flag", 4'(bus.Busy), 4'd1);
            tick();
        end
        bus.MDone = 1'b1; bus.MFlags = 4'b0100; #1;
        check("mdone_mregwrite", 4'(bus.MRegWrite), 4'd1);
        check("mdone_stall", 4'(bus.Stall), 4'd0);
        check("mdone_bypass_beq", 4'(bus.PCSrc), 4'd1);
        tick(); clear(); #1;
        check("mul_flags_written", bus.Flags, 4'b0100);
        check("mul_idle", 4'(bus.Busy), 4'd0);

        // Back-to-back: completion and new start in the same cycle.
        bus.MS = 1'b1; bus.FlagW = 4'b0011;
        tick(); clear();
        bus.MS = 1'b1; bus.FlagW = 4'b1000; bus.MDone = 1'b1; bus.MFlags = 4'b1111; #1;
        check("b2b_mstart", 4'(bus.MStart), 4'd1);
        check("b2b_mregwrite", 4'(bus.MRegWrite), 4'd1);
        tick(); clear(); #1;
        check("b2b_busy", 4'(bus.Busy), 4'd1);
        check("b2b_first_flags", bus.Flags, 4'b0111);
        bus.MDone = 1'b1; bus.MFlags = 4'b1000;
        tick(); clear(); #1;
        check("b2b_second_flags", bus.Flags, 4'b1111);
        check("b2b_idle", 4'(bus.Busy), 4'd0);

        // Stray MDone in IDLE.
        bus.MDone = 1'b1; #1;
        check("stray_mdone", 4'(bus.MRegWrite), 4'd0);
        tick(); clear(); #1;
        check("stray_flags", bus.Flags, 4'b1111);

        // Reset while BUSY abandons the op.
        bus.MS = 1'b1; bus.FlagW = 4'b1111;
        tick(); clear();
        Reset = 1'b1; #1;
        check("rst_busy", 4'(bus.Busy), 4'd0);
        check("rst_stall", 4'(bus.Stall), 4'd0);
        check("rst_flags", bus.Flags, 4'b0000);
        tick();
        Reset = 1'b0; bus.MDone = 1'b1; bus.MFlags = 4'b1111; #1;
        check("post_rst_mdone", 4'(bus.MRegWrite), 4'd0);
        bus.BankSel = 2'd1; #1;
        check("post_rst_bank1", bus.Flags, 4'b0000);

        // NV condition suppresses everything.
        tick(); clear();
        bus.Cond = 4'b1111; bus.PCS = 1'b1; bus.RegW = 1'b1; bus.MemW = 1'b1; bus.MS = 1'b1; #1;
        check("nv_enables", {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.MStart}, 4'b0000);

        // Randomized traffic; the compare process checks every cycle.
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (Reset) Reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) Reset = 1'b1;
            bus.Cond         = 4'($urandom_range(0, 15));
            bus.BankSel      = 2'($urandom_range(0, 3));
            bus.FlagW        = 4'($urandom_range(0, 15));
            bus.PCS          = 1'($urandom_range(0, 1));
            bus.RegW         = 1'($urandom_range(0, 1));
            bus.MemW         = 1'($urandom_range(0, 1));
            bus.NoWrite      = ($urandom_range(0, 3) == 0);
            bus.LogicOp      = 1'($urandom_range(0, 1));
            bus.ALUFlags     = 4'($urandom_range(0, 15));
            bus.ShifterCarry = 1'($urandom_range(0, 1));
            bus.MS           = ($urandom_range(0, 3) == 0);
            bus.FlagLoad     = !bus.MS && ($urandom_range(0, 7) == 0);
            bus.FlagIn       = 4'($urandom_range(0, 15));
            bus.MDone        = ($urandom_range(0, 2) == 0);
            bus.MFlags       = 4'($urandom_range(0, 15));
        end
        tick();
        Reset = 1'b0;
        clear();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
